cf_compress_reg: RTL and testbench
==================================

CF_COMPRESS_REG -- requirements
Module: cf_compress_reg

Interface
REQ-001 SHALL have parameter LFSR_INIT, default 16'hACE1, the PRNG state after reset and the substitute for an all-zero seed.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid  input  1  cf_q carries a valid set of component-function outputs.
REQ-005 SHALL have port in_ready  output  1  the block accepts cf_q in this cycle.
REQ-006 SHALL have port cf_q  input  18  outputs of component functions 0..17, bit n = function n.
REQ-007 SHALL have port out_valid  output  1  y1/y2 hold a valid compressed result.
REQ-008 SHALL have port out_ready  input  1  the consumer accepts y1/y2.
REQ-009 SHALL have port y1  output  3  three shares of the first nonlinear layer.
REQ-010 SHALL have port y2  output  3  three shares of the second nonlinear layer.
REQ-011 SHALL have port r1  output  6  fresh mask bits for functions 1..8.
REQ-012 SHALL have port r2  output  6  fresh mask bits for functions 10..17.
REQ-013 SHALL have port seed_load  input  1  load seed into the PRNG.
REQ-014 SHALL have port seed  input  16  PRNG seed value.

Function
REQ-015 SHALL implement stage A as an 18-bit register holding cf_q unmodified (no logic before the flop, to stop glitch propagation) plus valid bit vA.
REQ-016 SHALL implement stage B as 6 registered bits plus valid bit vB: y1[i] = A[3i]^A[3i+1]^A[3i+2], y2[i] = A[9+3i]^A[9+3i+1]^A[9+3i+2], for i=0..2.
REQ-017 SHALL drive y1/y2 directly from the stage-B flops and out_valid=vB; latency is 2 cycles from acceptance to out_valid when there is no backpressure.
REQ-018 SHALL define advB = vA && (!vB || out_ready) and in_ready = !vA || advB; stage A loads on in_valid&&in_ready.
REQ-019 SHALL hold stage B contents and vB stable while out_valid && !out_ready.
REQ-020 SHALL sustain a throughput of 1 transfer/cycle when out_ready is held at 1.
REQ-021 SHALL implement the PRNG as a 16-bit Fibonacci LFSR: next = {s[14:0], s[15]^s[13]^s[12]^s[10]}; r1 = s[5:0], r2 = s[11:6].
REQ-022 SHALL advance the LFSR exactly once per accepted transfer (in_valid&&in_ready) and hold it otherwise, so each accepted cf_q uses a distinct r1/r2.
REQ-023 SHALL on seed_load load seed, or LFSR_INIT if seed==0; seed_load takes priority over an advance in the same cycle.
REQ-024 SHALL never hold the LFSR at all-zero.

Reset
REQ-025 SHALL on rst_n low immediately clear vA, vB, stage A and stage B to 0, and set the LFSR to LFSR_INIT.
REQ-026 SHALL after reset present out_valid=0, y1=y2=0, in_ready=1, r1=6'h21, r2=6'h33.
REQ-027 SHALL on reset mid-operation discard all in-flight data, with no out_valid pulse following release.

Structure
REQ-028 SHALL place LFSR_INIT, the tap positions and the share/group widths (3 shares, 18 functions) in the shared masking package.
REQ-029 SHALL implement the LFSR in a sub-module named mask_prng16; the pipeline stays in cf_compress_reg.

Verification
REQ-030 SHALL cover: reset, then cf_q=18'h00007 accepted with out_ready=1 -> two cycles later out_valid=1, y1=3'b001, y2=3'b000.
REQ-031 SHALL cover: cf_q=18'h3FFFF -> y1=3'b111, y2=3'b111; cf_q=18'h00003 -> y1=3'b000.
REQ-032 SHALL cover: one accepted transfer after reset -> LFSR=16'h59C3; no transfer -> r1/r2 unchanged.
REQ-033 SHALL cover: out_ready=0 while 3 transfers are offered -> exactly 2 accepted, in_ready=0 thereafter, y held; on release, outputs appear in order with no loss or duplication.
REQ-034 SHALL cover: seed_load with seed=0 together with in_valid -> LFSR=16'hACE1; seed=16'h1234 -> r1=6'h34, r2=6'h08.
REQ-035 SHALL cover: rst_n asserted while vA=vB=1 -> out_valid=0 at once, and no stale output after release.

Source files
------------

// File: rtl/cf_compress_reg_pkg.sv
// Shared masking package: share/group geometry, PRNG defaults and taps,
// and the compressed-output payload type.
package cf_compress_reg_pkg;

  localparam int unsigned NUM_SHARES = 3;
  localparam int unsigned NUM_FUNCS  = 18;
  localparam int unsigned NUM_GROUPS = NUM_FUNCS / NUM_SHARES;
  localparam int unsigned LAYER_W    = NUM_GROUPS / 2;
  localparam int unsigned LFSR_W     = 16;
  localparam int unsigned MASK_W     = 6;

  localparam logic [LFSR_W-1:0] LFSR_INIT_DEFAULT = 16'hACE1;
  // Feedback taps at bits 15, 13, 12 and 10
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  // Compressed result: one share-sum bit per group for each nonlinear layer
  typedef struct packed {
    logic [LAYER_W-1:0] y2;
    logic [LAYER_W-1:0] y1;
  } cf_out_t;

  // One step of the Fibonacci LFSR: shift left, feedback enters at bit 0
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/mask_prng16.sv
// 16-bit Fibonacci LFSR supplying fresh mask bits.
// Ports: clk, rst_n (async, active-low), advance (step once),
//        seed_load/seed (load seed, zero seed replaced by INIT),
//        mask (low 12 state bits, {r2, r1}).
module mask_prng16
  import cf_compress_reg_pkg::*;
#(
  parameter logic [LFSR_W-1:0] INIT = LFSR_INIT_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  input  logic                  seed_load,
  input  logic [LFSR_W-1:0]     seed,
  output logic [2*MASK_W-1:0]   mask
);

  logic [LFSR_W-1:0] r_state;

  // Seed load wins over advance; an all-zero seed would lock the LFSR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= INIT;
    end else if (seed_load) begin
      r_state <= (seed == '0) ? INIT : seed;
    end else if (advance) begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign mask = r_state[2*MASK_W-1:0];

endmodule

// File: rtl/cf_compress_reg.sv
// Two-stage compression of 18 masked component-function outputs into
// two 3-share layers, with valid/ready flow control and a mask PRNG.
// Ports: clk, rst_n (async, active-low); in_valid/in_ready/cf_q input
//        handshake; out_valid/out_ready/y1/y2 output handshake;
//        r1/r2 fresh mask bits; seed_load/seed PRNG seeding.
module cf_compress_reg
  import cf_compress_reg_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_INIT = LFSR_INIT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [NUM_FUNCS-1:0] cf_q,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LAYER_W-1:0]   y1,
  output logic [LAYER_W-1:0]   y2,
  output logic [MASK_W-1:0]    r1,
  output logic [MASK_W-1:0]    r2,
  input  logic                 seed_load,
  input  logic [LFSR_W-1:0]    seed
);

  logic [NUM_FUNCS-1:0] r_a;
  logic                 r_va;
  cf_out_t              r_b;
  logic                 r_vb;
  logic                 w_adv_b;
  logic                 w_accept;
  cf_out_t              w_b_next;
  logic [2*MASK_W-1:0]  w_mask;

  // Handshake: stage B takes A when empty or being drained
  always_comb begin
    w_adv_b  = r_va && (!r_vb || out_ready);
    in_ready = !r_va || w_adv_b;
    w_accept = in_valid && in_ready;
  end

  // Share sums of each 3-function group, taken only from stage-A flops
  always_comb begin
    w_b_next = '0;
    for (int unsigned i = 0; i < LAYER_W; i++) begin
      w_b_next.y1[i] = ^r_a[NUM_SHARES*i +: NUM_SHARES];
      w_b_next.y2[i] = ^r_a[LAYER_W*NUM_SHARES + NUM_SHARES*i +: NUM_SHARES];
    end
  end

  // Stage A: raw capture, no logic ahead of the flop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_va <= 1'b0;
    end else if (w_accept) begin
      r_a  <= cf_q;
      r_va <= 1'b1;
    end else if (w_adv_b) begin
      r_va <= 1'b0;
    end
  end

  // Stage B: holds contents while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_b  <= '0;
      r_vb <= 1'b0;
    end else if (w_adv_b) begin
      r_b  <= w_b_next;
      r_vb <= 1'b1;
    end else if (out_ready) begin
      r_vb <= 1'b0;
    end
  end

  assign out_valid = r_vb;
  assign y1        = r_b.y1;
  assign y2        = r_b.y2;

  // One LFSR step per accepted input so each transfer sees distinct masks
  mask_prng16 #(
    .INIT (LFSR_INIT)
  ) u_prng (
    .clk       (clk),
    .rst_n     (rst_n),
    .advance   (w_accept),
    .seed_load (seed_load),
    .seed      (seed),
    .mask      (w_mask)
  );

  assign r1 = w_mask[MASK_W-1:0];
  assign r2 = w_mask[2*MASK_W-1:MASK_W];

endmodule

// File: tb/tb_cf_compress_reg.sv
// Scoreboard bench for cf_compress_reg: directed corner cases followed by
// randomized traffic, checked against a behavioural reference model.
module tb_cf_compress_reg;

  localparam logic [15:0] INIT = 16'hACE1;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] cf_q;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  y1;
  logic [2:0]  y2;
  logic [5:0]  r1;
  logic [5:0]  r2;
  logic        seed_load;
  logic [15:0] seed;

  int n_chk = 0;
  int n_err = 0;

  logic [5:0]  sb[$];   // expected {y2, y1} in acceptance order
  logic [15:0] m_lfsr;  // reference PRNG state

  cf_compress_reg #(.LFSR_INIT(INIT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cf_q      (cf_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y1        (y1),
    .y2        (y2),
    .r1        (r1),
    .r2        (r2),
    .seed_load (seed_load),
    .seed      (seed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: y1[i] is the parity of functions 3i..3i+2, y2[i] of 9+3i..9+3i+2
  function automatic logic [5:0] model_compress(input logic [17:0] d);
    logic [5:0] res;
    int ones;
    res = '0;
    for (int g = 0; g < 6; g++) begin
      ones = 0;
      for (int b = 0; b < 3; b++) ones += int'(d[3*g + b]);
      res[g] = (ones % 2) == 1;
    end
    return res;
  endfunction

  function automatic logic [15:0] model_step(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // Input side: reference PRNG and scoreboard pushes
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_lfsr = INIT;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_y", 32'({y2, y1}), 32'd0);
    end
    chk("r1", 32'(r1), 32'(m_lfsr[5:0]));
    chk("r2", 32'(r2), 32'(m_lfsr[11:6]));
    if (rst_n) begin
      if (in_valid && in_ready) sb.push_back(model_compress(cf_q));
      if (seed_load) m_lfsr = (seed == 16'h0) ? INIT : seed;
      else if (in_valid && in_ready) m_lfsr = model_step(m_lfsr);
    end
  end

  // Output side: every presented result must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        chk("y1", 32'(y1), 32'(sb[0][2:0]));
        chk("y2", 32'(y2), 32'(sb[0][5:3]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [17:0] d);
    logic ok;
    ok = 1'b0;
    in_valid = 1'b1;
    cf_q = d;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("send_accept", 32'(ok), 32'd1);
  endtask

  initial begin
    logic [17:0] bp[3];
    int cnt;
    int k;
    rst_n = 1'b1; in_valid = 1'b0; cf_q = '0; out_ready = 1'b0;
    seed_load = 1'b0; seed = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // First transfer: latency and the first LFSR step (ACE1 -> 59C3)
    in_valid = 1'b1; cf_q = 18'h00007; out_ready = 1'b1;
    @(negedge clk);
    chk("first_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    chk("lat1_out_valid", 32'(out_valid), 32'd0);
    chk("lfsr1_r1", 32'(r1), 32'h03);
    chk("lfsr1_r2", 32'(r2), 32'h27);
    tick();
    chk("lat2_out_valid", 32'(out_valid), 32'd1);
    chk("lat2_y1", 32'(y1), 32'h1);
    chk("lat2_y2", 32'(y2), 32'h0);
    tick();
    chk("idle_r1", 32'(r1), 32'h03);
    chk("idle_r2", 32'(r2), 32'h27);

    send(18'h3FFFF);
    send(18'h00003);
    repeat (4) tick();

    // Full throughput with the consumer always ready
    cnt = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cf_q = 18'($urandom);
      @(negedge clk);
      if (in_ready) cnt++;
      tick();
    end
    in_valid = 1'b0;
    chk("throughput", 32'(cnt), 32'd20);
    repeat (4) tick();

    // Backpressure: three offered, only two fit
    bp[0] = 18'h2A5C3; bp[1] = 18'h15A3C; bp[2] = 18'h0F0F0;
    out_ready = 1'b0; in_valid = 1'b1; cnt = 0; k = 0;
    for (int c = 0; c < 6; c++) begin
      cf_q = bp[k];
      @(negedge clk);
      if (in_ready) begin cnt++; k++; end
      tick();
    end
    chk("bp_accepted", 32'(cnt), 32'd2);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    send(bp[2]);
    repeat (5) tick();
    chk("bp_drained", 32'(sb.size()), 32'd0);

    // Seeding: zero seed falls back to INIT and overrides the advance
    in_valid = 1'b1; cf_q = 18'h12345; seed_load = 1'b1; seed = 16'h0000;
    tick();
    in_valid = 1'b0;
    chk("seed0_r1", 32'(r1), 32'h21);
    chk("seed0_r2", 32'(r2), 32'h33);
    seed = 16'h1234;
    tick();
    seed_load = 1'b0;
    chk("seed_r1", 32'(r1), 32'h34);
    chk("seed_r2", 32'(r2), 32'h08);
    repeat (4) tick();

    // Reset with both stages full
    out_ready = 1'b0;
    send(18'h00FFF);
    send(18'h3F000);
    chk("full_out_valid", 32'(out_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_y", 32'({y2, y1}), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("post_rst_quiet", 32'(out_valid), 32'd0);
    end

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom % 4) != 0;
      cf_q      = 18'($urandom);
      out_ready = ($urandom % 3) != 0;
      seed_load = ($urandom % 50) == 0;
      seed      = (($urandom % 2) == 0) ? 16'h0000 : 16'($urandom);
      tick();
    end
    in_valid = 1'b0; seed_load = 1'b0; out_ready = 1'b1;
    repeat (6) tick();
    chk("final_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
